// File: rtl/uart_echo_initiator.sv
// UART loopback test initiator: sends a sync header, waits for its echo, then
// streams a burst of seed+index bytes and scores the echoed bytes against them.
module uart_echo_initiator #(
   parameter logic [7:0]  HEADER_BYTE    = 8'hAA,
   parameter int unsigned BURST_LEN      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
   input  logic       clk_50mhz,
   input  logic       reset_n_internal,
   input  logic       i_start,
   input  logic [7:0] i_seed,
   output logic       o_tx_dv,
   output logic [7:0] o_tx_byte,
   input  logic       i_tx_done,
   input  logic       i_rx_dv,
   input  logic [7:0] i_rx_byte,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_pass,
   output logic       o_timeout,
   output logic [7:0] o_err_count
);

   typedef enum logic [2:0] {
      IDLE, SEND_HDR, WAIT_HDR_TX, WAIT_HDR_ECHO,
      SEND_DATA, WAIT_DATA_TX, WAIT_ECHOES, DONE
   } state_e;

   localparam logic [7:0]    BURST_LAST = 8'(BURST_LEN);
   localparam int            TW         = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   state_e        state_q, state_d;
   logic [7:0]    seed_q, seed_d;
   logic [7:0]    tx_idx_q, tx_idx_d;
   logic [7:0]    rx_idx_q, rx_idx_d;
   logic [7:0]    err_q, err_d;
   logic          pass_q, pass_d;
   logic          tmo_flag_q, tmo_flag_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

   logic [7:0] exp_rx_byte;
   logic       scoring, active, result_ok;

   assign exp_rx_byte = seed_q + rx_idx_q;
   assign scoring     = (state_q == SEND_DATA) || (state_q == WAIT_DATA_TX) ||
                        (state_q == WAIT_ECHOES);
   assign active      = (state_q != IDLE) && (state_q != DONE);
   assign result_ok   = (err_q == 8'h00) && !tmo_flag_q;

   // NOTE: every variable gets its default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      state_d    = state_q;
      seed_d     = seed_q;
      tx_idx_d   = tx_idx_q;
      rx_idx_d   = rx_idx_q;
      err_d      = err_q;
      pass_d     = pass_q;
      tmo_flag_d = tmo_flag_q;

      // Echoes are scored in every data state, so a late echo may overlap the next transmit.
      if (scoring && i_rx_dv && (rx_idx_q < BURST_LAST)) begin
         rx_idx_d = rx_idx_q + 8'd1;
         if ((i_rx_byte != exp_rx_byte) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
      end

      unique case (state_q)
         IDLE: if (i_start) begin
            seed_d     = i_seed;
            err_d      = 8'h00;
            pass_d     = 1'b0;
            tmo_flag_d = 1'b0;
            tx_idx_d   = 8'h00;
            rx_idx_d   = 8'h00;
            state_d    = SEND_HDR;
         end
         SEND_HDR:      state_d = WAIT_HDR_TX;
         WAIT_HDR_TX:   if (i_tx_done) state_d = WAIT_HDR_ECHO;
         WAIT_HDR_ECHO: if (i_rx_dv && (i_rx_byte == HEADER_BYTE)) state_d = SEND_DATA;
         SEND_DATA: begin
            tx_idx_d = tx_idx_q + 8'd1;
            state_d  = WAIT_DATA_TX;
         end
         WAIT_DATA_TX: if (i_tx_done) begin
            if (tx_idx_q < BURST_LAST)       state_d = SEND_DATA;
            else if (rx_idx_d == BURST_LAST) state_d = DONE;
            else                             state_d = WAIT_ECHOES;
         end
         WAIT_ECHOES: if (rx_idx_d == BURST_LAST) state_d = DONE;
         DONE: begin
            pass_d  = result_ok;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (active && (tmo_cnt_q == TMO_LAST)) begin
         tmo_flag_d = 1'b1;
         state_d    = DONE;
      end

      if (!active || (state_d != state_q) || i_rx_dv || i_tx_done) tmo_cnt_d = '0;
      else                                                          tmo_cnt_d = tmo_cnt_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk_50mhz or negedge reset_n_internal) begin
      if (!reset_n_internal) begin
         state_q    <= IDLE;
         seed_q     <= 8'h00;
         tx_idx_q   <= 8'h00;
         rx_idx_q   <= 8'h00;
         err_q      <= 8'h00;
         pass_q     <= 1'b0;
         tmo_flag_q <= 1'b0;
         tmo_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         seed_q     <= seed_d;
         tx_idx_q   <= tx_idx_d;
         rx_idx_q   <= rx_idx_d;
         err_q      <= err_d;
         pass_q     <= pass_d;
         tmo_flag_q <= tmo_flag_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

   // Outputs decode from state so an asynchronous reset clears them immediately.
   assign o_tx_dv     = (state_q == SEND_HDR) || (state_q == SEND_DATA);
   assign o_tx_byte   = (state_q == SEND_HDR)  ? HEADER_BYTE :
                        (state_q == SEND_DATA) ? (seed_q + tx_idx_q) : 8'h00;
   assign o_busy      = active;
   assign o_done      = (state_q == DONE);
   assign o_pass      = (state_q == DONE) ? result_ok : pass_q;
   assign o_timeout   = tmo_flag_q;
   assign o_err_count = err_q;

endmodule

// File: tb/tb_uart_echo_initiator.sv
// Directed bench: a loopback UART model echoes each byte, a scoreboard checks
// the transmitted sequence, and per-test results are compared at o_done.
module tb_uart_echo_initiator;

   localparam logic [7:0] HDR = 8'hAA;
   localparam int         BL  = 4;

   logic       clk_50mhz = 1'b0;
   logic       reset_n_internal;
   logic       i_start;
   logic [7:0] i_seed;
   logic       o_tx_dv;
   logic [7:0] o_tx_byte;
   logic       i_tx_done;
   logic       i_rx_dv;
   logic [7:0] i_rx_byte;
   logic       o_busy, o_done, o_pass, o_timeout;
   logic [7:0] o_err_count;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;

   logic [8:0] exp_q[$];

   // Loopback model configuration
   int         m_cnt     = 0;
   int         m_mode    = 0;  // 0: echo with done, 1: echo before done, 2: echo after done
   int         m_corrupt = -1;
   bit         m_junk    = 1'b0;
   bit         m_echo_hdr = 1'b1;
   bit         pend      = 1'b0;
   logic [7:0] pend_b;

   always #10 clk_50mhz = ~clk_50mhz;

   uart_echo_initiator #(.HEADER_BYTE(HDR), .BURST_LEN(BL), .TIMEOUT_CYCLES(1000)) dut (
      .clk_50mhz(clk_50mhz), .reset_n_internal(reset_n_internal),
      .i_start(i_start), .i_seed(i_seed),
      .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte), .i_tx_done(i_tx_done),
      .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
      .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
      .o_timeout(o_timeout), .o_err_count(o_err_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_50mhz);
      i_tx_done = 1'b0;
      i_rx_dv   = 1'b0;
   endtask

   // UART transmitter + loopback line model
   initial begin
      logic [7:0] b, eb;
      i_tx_done = 1'b0;
      i_rx_dv   = 1'b0;
      i_rx_byte = 8'h00;
      forever begin
         tick();
         if (pend) begin
            i_rx_dv   = 1'b1;
            i_rx_byte = pend_b;
            pend      = 1'b0;
         end
         if (o_tx_dv) begin
            b = o_tx_byte;
            tick(); tick(); tick();
            if (m_cnt == 0) begin
               i_tx_done = 1'b1;
               tick();
               if (m_junk) begin
                  i_rx_byte = 8'h55; i_rx_dv = 1'b1; tick();
                  i_rx_byte = 8'h00; i_rx_dv = 1'b1; tick();
               end
               if (m_echo_hdr) begin
                  i_rx_byte = b; i_rx_dv = 1'b1;
               end
            end else begin
               eb = (m_cnt - 1 == m_corrupt) ? b + 8'd1 : b;
               case (m_mode)
                  0: begin i_tx_done = 1'b1; i_rx_dv = 1'b1; i_rx_byte = eb; end
                  1: begin i_rx_dv = 1'b1; i_rx_byte = eb; tick(); i_tx_done = 1'b1; end
                  default: begin i_tx_done = 1'b1; pend_b = eb; pend = 1'b1; end
               endcase
            end
            m_cnt++;
         end
      end
   end

   // Scoreboard: every transmit strobe pops the next expected byte
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk_50mhz);
         if (o_tx_dv) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
            check("tx_byte", {24'd0, o_tx_byte}, {23'd0, e});
            check("tx_busy", {31'd0, o_busy}, 32'd1);
         end
      end
   end

   always @(negedge clk_50mhz) if (o_done) done_cnt++;

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_dv"},   {31'd0, o_tx_dv},   32'd0);
      check({tag, "_tx_byte"}, {24'd0, o_tx_byte}, 32'd0);
      check({tag, "_busy"},    {31'd0, o_busy},    32'd0);
      check({tag, "_done"},    {31'd0, o_done},    32'd0);
      check({tag, "_pass"},    {31'd0, o_pass},    32'd0);
      check({tag, "_timeout"}, {31'd0, o_timeout}, 32'd0);
      check({tag, "_err"},     {24'd0, o_err_count}, 32'd0);
   endtask

   task automatic start_test(input logic [7:0] seed, input bit junk, input bit echo_hdr,
                             input int corrupt, input int mode);
      m_cnt = 0; m_junk = junk; m_echo_hdr = echo_hdr; m_corrupt = corrupt; m_mode = mode;
      exp_q.push_back({1'b0, HDR});
      if (echo_hdr) for (int i = 0; i < BL; i++) exp_q.push_back({1'b0, seed + 8'(i)});
      @(negedge clk_50mhz);
      i_seed = seed; i_start = 1'b1;
      @(negedge clk_50mhz);
      i_start = 1'b0; i_seed = 8'h77;
      check("start_busy",  {31'd0, o_busy},    32'd1);
      check("start_pass",  {31'd0, o_pass},    32'd0);
      check("start_tmo",   {31'd0, o_timeout}, 32'd0);
   endtask

   task automatic finish_test(input string tag, input int d0, input bit e_pass,
                              input int e_err, input bit e_tmo);
      bit got = 1'b0;
      for (int i = 0; i < 5000 && !got; i++) begin
         @(negedge clk_50mhz);
         if (o_done) got = 1'b1;
      end
      check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
      check({tag, "_pass"},      {31'd0, o_pass}, {31'd0, e_pass});
      check({tag, "_err"},       {24'd0, o_err_count}, 32'(e_err));
      check({tag, "_timeout"},   {31'd0, o_timeout}, {31'd0, e_tmo});
      check({tag, "_busy_done"}, {31'd0, o_busy}, 32'd0);
      @(negedge clk_50mhz);
      check({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
      check({tag, "_pass_held"},  {31'd0, o_pass}, {31'd0, e_pass});
      check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_tx_all"},     32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (5) @(negedge clk_50mhz);
   endtask

   initial begin
      int  d0;
      bit  hit;
      reset_n_internal = 1'b0;
      i_start = 1'b0;
      i_seed  = 8'h00;
      #5;
      check_reset_outputs("rst");
      repeat (3) @(negedge clk_50mhz);
      reset_n_internal = 1'b1;
      repeat (2) @(negedge clk_50mhz);

      // Ideal loopback, echo coincides with tx_done
      d0 = done_cnt;
      start_test(8'h10, 1'b0, 1'b1, -1, 0);
      finish_test("ideal", d0, 1'b1, 0, 1'b0);

      // Third data byte corrupted, echoes arrive after tx_done
      d0 = done_cnt;
      start_test(8'h10, 1'b0, 1'b1, 2, 2);
      finish_test("corrupt", d0, 1'b0, 1, 1'b0);

      // Junk before header echo, echoes precede tx_done
      d0 = done_cnt;
      start_test(8'h20, 1'b1, 1'b1, -1, 1);
      finish_test("junk", d0, 1'b1, 0, 1'b0);

      // Header never echoed
      d0 = done_cnt;
      start_test(8'h30, 1'b0, 1'b0, -1, 0);
      finish_test("timeout", d0, 1'b0, 0, 1'b1);

      // Seed wraps past 8'hFF, stray start mid-test
      d0 = done_cnt;
      start_test(8'hFE, 1'b0, 1'b1, -1, 0);
      repeat (10) @(negedge clk_50mhz);
      i_seed = 8'h33; i_start = 1'b1;
      @(negedge clk_50mhz);
      i_start = 1'b0;
      finish_test("wrap", d0, 1'b1, 0, 1'b0);

      // Reset while waiting for the second data byte's tx_done
      d0 = done_cnt;
      start_test(8'h40, 1'b0, 1'b1, -1, 0);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk_50mhz);
         if (o_tx_dv && o_tx_byte == 8'h41) hit = 1'b1;
      end
      check("abort_reached", {31'd0, hit}, 32'd1);
      @(negedge clk_50mhz);
      reset_n_internal = 1'b0;
      #1;
      check_reset_outputs("abort");
      repeat (10) @(negedge clk_50mhz);
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      reset_n_internal = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk_50mhz);
      d0 = done_cnt;
      start_test(8'h5C, 1'b0, 1'b1, -1, 1);
      finish_test("after_rst", d0, 1'b1, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_echo_initiator.md
UART_ECHO_INITIATOR -- requirements
Module: uart_echo_initiator

Interface
REQ-001 SHALL have parameter HEADER_BYTE, default 8'hAA: sync byte sent first and expected back.
REQ-002 SHALL have parameter BURST_LEN, default 4, range 1-255: data bytes per test burst.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2_500_000: inactivity limit, 100 ms at 25 MHz.
REQ-004 SHALL have port clk_50mhz  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port reset_n_internal  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_start  input  1  one-cycle request to run one test burst.
REQ-007 SHALL have port i_seed  input  8  first data byte of the burst; latched when a start is accepted.
REQ-008 SHALL have port o_tx_dv  output  1  one-cycle transmit strobe to the UART transmitter.
REQ-009 SHALL have port o_tx_byte  output  8  byte to transmit; valid while o_tx_dv=1.
REQ-010 SHALL have port i_tx_done  input  1  one-cycle pulse when the UART finishes a byte.
REQ-011 SHALL have port i_rx_dv / i_rx_byte  input  1/8  received byte strobe and data.
REQ-012 SHALL have port o_busy  output  1  high from start acceptance until o_done.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse at test end.
REQ-014 SHALL have port o_pass  output  1  result of the last test; held until the next start.
REQ-015 SHALL have port o_timeout  output  1  last test ended by timeout; held until the next start.
REQ-016 SHALL have port o_err_count  output  8  data mismatches in the last test, saturating at 255.

Function
REQ-017 SHALL implement states IDLE, SEND_HDR, WAIT_HDR_TX, WAIT_HDR_ECHO, SEND_DATA, WAIT_DATA_TX, WAIT_ECHOES, DONE.
REQ-018 IDLE: on i_start=1, SHALL latch i_seed, clear o_err_count, o_pass and o_timeout, zero tx_idx and rx_idx, set o_busy, and go to SEND_HDR; i_start SHALL be ignored in every other state.
REQ-019 SEND_HDR: SHALL drive o_tx_dv=1 with o_tx_byte=HEADER_BYTE for exactly one cycle, then go to WAIT_HDR_TX.
REQ-020 WAIT_HDR_TX: on i_tx_done, SHALL go to WAIT_HDR_ECHO.
REQ-021 WAIT_HDR_ECHO: on i_rx_dv with i_rx_byte==HEADER_BYTE, SHALL go to SEND_DATA; other received bytes SHALL be discarded and not counted.
REQ-022 SEND_DATA: SHALL pulse o_tx_dv for one cycle with o_tx_byte = seed + tx_idx (mod 256), increment tx_idx, and go to WAIT_DATA_TX.
REQ-023 WAIT_DATA_TX: on i_tx_done, SHALL go to SEND_DATA if tx_idx < BURST_LEN, else to WAIT_ECHOES.
REQ-024 At most one o_tx_dv SHALL be outstanding: no new o_tx_dv before the i_tx_done of the previous byte.
REQ-025 In SEND_DATA, WAIT_DATA_TX and WAIT_ECHOES, each i_rx_dv with rx_idx < BURST_LEN SHALL compare i_rx_byte with seed + rx_idx (mod 256).
REQ-026 On that compare, SHALL increment o_err_count on mismatch (saturating at 255) and SHALL increment rx_idx.
REQ-027 Received bytes with rx_idx == BURST_LEN SHALL be ignored.
REQ-028 When rx_idx reaches BURST_LEN and tx_idx == BURST_LEN with the last i_tx_done seen, SHALL go to DONE; this includes the case where the last echo arrives before the last i_tx_done.
REQ-029 If i_rx_dv and i_tx_done occur in the same cycle, SHALL process both in that cycle.
REQ-030 SHALL run a timeout counter in every state except IDLE and DONE: clear it on state entry and on each i_rx_dv or i_tx_done, otherwise increment it.
REQ-031 When the timeout counter reaches TIMEOUT_CYCLES-1, SHALL set o_timeout=1 and go to DONE.
REQ-032 DONE: for one cycle, SHALL set o_done=1, clear o_busy, and set o_pass=1 iff o_err_count==0 and o_timeout==0; then go to IDLE.
REQ-033 i_rx_dv in IDLE SHALL be ignored.

Reset
REQ-034 On reset_n_internal=0, SHALL go to IDLE immediately, including mid-test, and SHALL clear all counters and indices.
REQ-035 On reset, o_tx_dv, o_busy, o_done, o_pass and o_timeout SHALL be 0, and o_tx_byte and o_err_count SHALL be 8'h00.
REQ-036 A test aborted by reset SHALL produce no o_done.

Verification
REQ-037 Ideal loopback, seed 8'h10, BURST_LEN 4 -> TX sequence AA,10,11,12,13; one o_done; o_pass=1, o_err_count=0.
REQ-038 Echo model corrupts the 3rd data byte (12 -> 13) -> o_pass=0, o_err_count=1, o_timeout=0.
REQ-039 Junk bytes 55,00 arrive before the AA echo -> both ignored; test passes.
REQ-040 No header echo -> after TIMEOUT_CYCLES (reduced to 1000 in sim), o_timeout=1, o_pass=0, no data bytes sent.
REQ-041 Seed 8'hFE, BURST_LEN 4 -> data FE,FF,00,01 (wrap); test passes; i_start pulsed mid-test has no effect.
REQ-042 Reset asserted during WAIT_DATA_TX -> all outputs at reset values within the same cycle; no o_done; a new start then passes.
